// File: rtl/div16by8_seq.sv
// Sequential restoring divider (16-bit dividend / 8-bit divisor), one quotient bit per cycle.
// Define DIV_APPROX_EN for the truncated 6-iteration variant that ignores O[1:0] and reports R=0.
module div16by8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] O,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  Q,
  output logic [7:0]  R,
  output logic        ovf,
  output logic        dz
);

`ifdef DIV_APPROX_EN
  localparam int ITER = 6;
`else
  localparam int ITER = 8;
`endif
  localparam logic [2:0] CNT_LAST = 3'(ITER - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r;
  logic [7:0]  div_r;
  logic [7:0]  rem_r;
  logic [7:0]  quo_r;
  logic [7:0]  dvd_r;
  logic [2:0]  cnt_r;
  logic        ovf_r;
  logic        dz_r;

  logic [8:0]  trial_s;
  logic        qbit_s;
  logic [7:0]  rem_nxt_s;
  logic [7:0]  q_fin_s;
  logic [7:0]  r_fin_s;

  // One restoring step: rem stays below the divisor, so the difference always fits in 8 bits
  always_comb begin
    trial_s   = {rem_r, dvd_r[7]};
    qbit_s    = 1'b0;
    rem_nxt_s = trial_s[7:0];
    if (trial_s >= {1'b0, div_r}) begin
      qbit_s    = 1'b1;
      rem_nxt_s = trial_s[7:0] - div_r;
    end else begin
      qbit_s    = 1'b0;
      rem_nxt_s = trial_s[7:0];
    end
  end

  // Final result formatting for the normal (non-exception) path
  always_comb begin
    q_fin_s = 8'h00;
    r_fin_s = 8'h00;
`ifdef DIV_APPROX_EN
    q_fin_s = {quo_r[5:0], 2'b00};
    r_fin_s = 8'h00;
`else
    q_fin_s = quo_r;
    r_fin_s = rem_r;
`endif
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Q         <= 8'h00;
      R         <= 8'h00;
      ovf       <= 1'b0;
      dz        <= 1'b0;
      div_r     <= 8'h00;
      rem_r     <= 8'h00;
      quo_r     <= 8'h00;
      dvd_r     <= 8'h00;
      cnt_r     <= 3'd0;
      ovf_r     <= 1'b0;
      dz_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            div_r    <= B;
            dvd_r    <= O[7:0];
            quo_r    <= 8'h00;
            cnt_r    <= CNT_LAST;
            in_ready <= 1'b0;
            if (B == 8'h00) begin
              dz_r    <= 1'b1;
              ovf_r   <= 1'b0;
              rem_r   <= 8'h00;
              state_r <= DONE;
            end else if (O[15:8] >= B) begin
              // High half already >= divisor: quotient cannot fit in 8 bits
              dz_r    <= 1'b0;
              ovf_r   <= 1'b1;
              rem_r   <= 8'h00;
              state_r <= DONE;
            end else begin
              dz_r    <= 1'b0;
              ovf_r   <= 1'b0;
              rem_r   <= O[15:8];
              state_r <= DIV;
            end
          end
        end
        DIV: begin
          rem_r <= rem_nxt_s;
          quo_r <= {quo_r[6:0], qbit_s};
          dvd_r <= {dvd_r[6:0], 1'b0};
          cnt_r <= cnt_r - 3'd1;
          if (cnt_r == 3'd0) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            ovf       <= ovf_r;
            dz        <= dz_r;
            if (ovf_r || dz_r) begin
              Q <= 8'hFF;
              R <= 8'h00;
            end else begin
              Q <= q_fin_s;
              R <= r_fin_s;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div16by8_seq.sv
// Self-checking bench for div16by8_seq: directed table, handshake/reset corner cases, random sweep.
module tb_div16by8_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] O;
  logic [7:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  Q;
  logic [7:0]  R;
  logic        ovf;
  logic        dz;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DIV_APPROX_EN
  localparam int LAT_NORM = 7;
`else
  localparam int LAT_NORM = 9;
`endif

  typedef struct {
    logic [15:0] o;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ov;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  div16by8_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .O(O), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .ovf(ovf), .dz(dz)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer division on the operand values
  task automatic model(input logic [15:0] o, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic ov, output logic z, output int lat);
    int oi, bi;
    oi = int'(o);
    bi = int'(b);
    if (bi == 0) begin
      q = 8'hFF; r = 8'h00; ov = 1'b0; z = 1'b1; lat = 1;
    end else if (oi / bi > 255) begin
      q = 8'hFF; r = 8'h00; ov = 1'b1; z = 1'b0; lat = 1;
    end else begin
`ifdef DIV_APPROX_EN
      q = 8'(((oi / 4) / bi) * 4);
      r = 8'h00;
`else
      q = 8'(oi / bi);
      r = 8'(oi % bi);
`endif
      ov = 1'b0; z = 1'b0; lat = LAT_NORM;
    end
  endtask

  // Full transaction: offer operands, scramble them after acceptance, measure latency, drain.
  task automatic do_op(input logic [15:0] o, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic ov, output logic z, output int lat);
    int w;
    O = o; B = b; in_valid = 1'b1; w = 0;
    while (!in_ready && w < 20) begin step(); w++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    step();
    in_valid = 1'b0;
    O = 16'($urandom);
    B = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin step(); lat++; end
    q = Q; r = R; ov = ovf; z = dz;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0]  q, r, eq, er;
    logic        ov, z, eov, ez;
    logic [15:0] o;
    logic [7:0]  b;
    int          lat, elat, w, seen;

`ifdef DIV_APPROX_EN
    vecs[0] = '{16'h3039, 8'h7B, 8'h64, 8'h00, 1'b0, 1'b0, 7};
    vecs[1] = '{16'hFE01, 8'hFF, 8'hFC, 8'h00, 1'b0, 1'b0, 7};
    vecs[4] = '{16'h0064, 8'h0A, 8'h08, 8'h00, 1'b0, 1'b0, 7};
    vecs[6] = '{16'h00FF, 8'h01, 8'hFC, 8'h00, 1'b0, 1'b0, 7};
    vecs[5] = '{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 7};
`else
    vecs[0] = '{16'h3039, 8'h7B, 8'h64, 8'h2D, 1'b0, 1'b0, 9};
    vecs[1] = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 9};
    vecs[4] = '{16'h0064, 8'h0A, 8'h0A, 8'h00, 1'b0, 1'b0, 9};
    vecs[6] = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9};
    vecs[5] = '{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 9};
`endif
    vecs[2] = '{16'hFF00, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1};
    vecs[3] = '{16'h1234, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1};
    vecs[7] = '{16'h0100, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; O = 16'h0000; B = 8'h00;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_q", int'(Q), 0);
    chk("rst_r", int'(R), 0);
    chk("rst_flags", int'({ovf, dz}), 0);

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].o, vecs[i].b, q, r, ov, z, lat);
      chk($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].q));
      chk($sformatf("vec%0d_r", i), int'(r), int'(vecs[i].r));
      chk($sformatf("vec%0d_ovf", i), int'(ov), int'(vecs[i].ov));
      chk($sformatf("vec%0d_dz", i), int'(z), int'(vecs[i].z));
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_idle", i), int'({in_ready, out_valid}), 2);
    end

    // Backpressure: result must hold and new operands must be ignored
    O = 16'h3039; B = 8'h7B; in_valid = 1'b1;
    step();
    in_valid = 1'b0; w = 0;
    while (!out_valid && w < 40) begin step(); w++; end
    chk("hold_lat", w, LAT_NORM);
    in_valid = 1'b1; O = 16'h0064; B = 8'h0A;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_q", int'(Q), int'(vecs[0].q));
      chk("hold_r", int'(R), int'(vecs[0].r));
      chk("hold_flags", int'({ovf, dz}), 0);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_out_valid", int'(out_valid), 0);

    // Reset in the middle of a division discards it
    O = 16'h3039; B = 8'h7B; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_outputs", int'({Q, R, ovf, dz}), 0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (out_valid) seen++;
    end
    chk("midrst_discard", seen, 0);
    do_op(16'h0064, 8'h0A, q, r, ov, z, lat);
    chk("post_rst_q", int'(q), int'(vecs[4].q));
    chk("post_rst_r", int'(r), int'(vecs[4].r));
    chk("post_rst_lat", lat, LAT_NORM);

    // Random sweep against the model, biased so the normal path dominates
    for (int i = 0; i < 3000; i++) begin
      o = 16'($urandom);
      b = 8'($urandom);
      if (i % 32 == 0) b = 8'h00;
      if ((i % 4 != 0) && (b != 8'h00)) o[15:8] = 8'($urandom % int'(b));
      model(o, b, eq, er, eov, ez, elat);
      do_op(o, b, q, r, ov, z, lat);
      chk("rnd_q", int'(q), int'(eq));
      chk("rnd_r", int'(r), int'(er));
      chk("rnd_flags", int'({ov, z}), int'({eov, ez}));
      chk("rnd_lat", lat, elat);
`ifndef DIV_APPROX_EN
      if (!eov && !ez) begin
        chk("rnd_identity", int'(q) * int'(b) + int'(r), int'(o));
        chk("rnd_r_lt_b", int'(r < b), 1);
      end
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
